// File: rtl/reg_rename_file.sv
// Architectural register file with ROB rename tags; operand lookup is combinational (zero latency),
// commit/rename/flush land on the next posedge. No backpressure: every presented update is taken.
module reg_rename_file #(
    parameter int ROB_WIDTH_BIT = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_flag,
    input  logic [4:0]               commit_reg_id,
    input  logic [31:0]              commit_val,
    input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    input  logic [4:0]               new_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] new_rob_id,
    input  logic [4:0]               dec_rs1,
    input  logic [4:0]               dec_rs2,
    output logic [ROB_WIDTH_BIT-1:0] rob_q1_id,
    output logic [ROB_WIDTH_BIT-1:0] rob_q2_id,
    input  logic                     rob_q1_ready,
    input  logic                     rob_q2_ready,
    input  logic [31:0]              rob_q1_val,
    input  logic [31:0]              rob_q2_val,
    output logic                     rs1_dep,
    output logic                     rs2_dep,
    output logic [31:0]              rs1_val,
    output logic [31:0]              rs2_val,
    output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
    output logic [ROB_WIDTH_BIT-1:0] rs2_tag
);

    logic [31:0]              value [32];
    logic [ROB_WIDTH_BIT-1:0] tag   [32];
    logic [31:0]              busy;

    // Later assignments win: flush beats rename, rename beats the commit's busy clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy <= '0;
            for (int i = 0; i < 32; i++) begin
                value[i] <= '0;
                tag[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (commit_reg_id != 5'd0) begin
                value[commit_reg_id] <= commit_val;
                if (busy[commit_reg_id] && tag[commit_reg_id] == commit_rob_id)
                    busy[commit_reg_id] <= 1'b0;
            end
            if (clear_flag) begin
                busy <= '0;
                for (int i = 0; i < 32; i++)
                    tag[i] <= '0;
            end else if (new_reg_id != 5'd0) begin
                busy[new_reg_id] <= 1'b1;
                tag[new_reg_id]  <= new_rob_id;
            end
        end
    end

    assign rob_q1_id = tag[dec_rs1];
    assign rob_q2_id = tag[dec_rs2];

    always_comb begin
        rs1_dep = 1'b0;
        rs1_val = '0;
        rs1_tag = '0;
        if (dec_rs1 != 5'd0) begin
            if (!busy[dec_rs1])
                rs1_val = value[dec_rs1];
            else if (commit_reg_id == dec_rs1 && commit_rob_id == tag[dec_rs1])
                rs1_val = commit_val;
            else if (rob_q1_ready)
                rs1_val = rob_q1_val;
            else begin
                rs1_dep = 1'b1;
                rs1_tag = tag[dec_rs1];
            end
        end
    end

    always_comb begin
        rs2_dep = 1'b0;
        rs2_val = '0;
        rs2_tag = '0;
        if (dec_rs2 != 5'd0) begin
            if (!busy[dec_rs2])
                rs2_val = value[dec_rs2];
            else if (commit_reg_id == dec_rs2 && commit_rob_id == tag[dec_rs2])
                rs2_val = commit_val;
            else if (rob_q2_ready)
                rs2_val = rob_q2_val;
            else begin
                rs2_dep = 1'b1;
                rs2_tag = tag[dec_rs2];
            end
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed vector table plus randomized traffic checked against a register-file reference model.
module tb_reg_rename_file;

    localparam int RW = 5;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, clear_flag;
    logic [4:0]    commit_reg_id, new_reg_id, dec_rs1, dec_rs2;
    logic [31:0]   commit_val, rob_q1_val, rob_q2_val;
    logic [RW-1:0] commit_rob_id, new_rob_id, rob_q1_id, rob_q2_id, rs1_tag, rs2_tag;
    logic          rob_q1_ready, rob_q2_ready, rs1_dep, rs2_dep;
    logic [31:0]   rs1_val, rs2_val;

    reg_rename_file #(.ROB_WIDTH_BIT(RW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
        .commit_reg_id(commit_reg_id), .commit_val(commit_val), .commit_rob_id(commit_rob_id),
        .new_reg_id(new_reg_id), .new_rob_id(new_rob_id),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .rob_q1_id(rob_q1_id), .rob_q2_id(rob_q2_id),
        .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
        .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
        .rs1_dep(rs1_dep), .rs2_dep(rs2_dep), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference state: what each architectural register holds and which ROB entry (if any) owns it.
    logic [31:0]   mv [32];
    logic          mb [32];
    logic [RW-1:0] mt [32];

    typedef struct {
        logic rdy, clr;
        logic [4:0] creg; logic [31:0] cval; logic [RW-1:0] crob;
        logic [4:0] nreg; logic [RW-1:0] nrob;
        logic [4:0] rs1, rs2;
        logic q1r; logic [31:0] q1v; logic q2r; logic [31:0] q2v;
        logic d1; logic [31:0] v1; logic [RW-1:0] t1;
        logic d2; logic [31:0] v2; logic [RW-1:0] t2;
        logic [RW-1:0] qi1, qi2;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mv[i] = '0; mb[i] = 1'b0; mt[i] = '0;
        end
    endtask

    // Applies the architectural effect of the inputs present at this edge.
    task automatic model_edge();
        if (rst_in) begin
            model_reset();
        end else if (rdy_in) begin
            if (commit_reg_id != 0) begin
                mv[commit_reg_id] = commit_val;
                if (mb[commit_reg_id] && mt[commit_reg_id] == commit_rob_id)
                    mb[commit_reg_id] = 1'b0;
            end
            if (clear_flag) begin
                for (int i = 0; i < 32; i++) begin
                    mb[i] = 1'b0; mt[i] = '0;
                end
            end else if (new_reg_id != 0) begin
                mb[new_reg_id] = 1'b1;
                mt[new_reg_id] = new_rob_id;
            end
        end
    endtask

    task automatic model_query(input logic [4:0] rs, input logic qr, input logic [31:0] qv,
                               output logic d, output logic [31:0] v, output logic [RW-1:0] t);
        d = 1'b0; v = '0; t = '0;
        if (rs != 0) begin
            if (!mb[rs])
                v = mv[rs];
            else if (commit_reg_id == rs && commit_rob_id == mt[rs])
                v = commit_val;
            else if (qr)
                v = qv;
            else begin
                d = 1'b1; t = mt[rs];
            end
        end
    endtask

    task automatic clock_edge();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic drive(input vec_t v);
        rdy_in = v.rdy; clear_flag = v.clr;
        commit_reg_id = v.creg; commit_val = v.cval; commit_rob_id = v.crob;
        new_reg_id = v.nreg; new_rob_id = v.nrob;
        dec_rs1 = v.rs1; dec_rs2 = v.rs2;
        rob_q1_ready = v.q1r; rob_q1_val = v.q1v;
        rob_q2_ready = v.q2r; rob_q2_val = v.q2v;
    endtask

    initial begin
        logic d; logic [31:0] v; logic [RW-1:0] t;
        // rdy clr creg cval crob | nreg nrob | rs1 rs2 | q1r q1v q2r q2v | d1 v1 t1 | d2 v2 t2 | qi1 qi2
        vecs[0]  = '{1,0,5,32'h1234,3, 0,0,  5,0, 0,0,0,0,          0,0,0,        0,0,0,        0,0};
        vecs[1]  = '{1,0,0,0,0,        0,0,  5,0, 0,0,0,0,          0,32'h1234,0, 0,0,0,        0,0};
        vecs[2]  = '{1,0,0,0,0,        7,4,  7,0, 0,0,0,0,          0,0,0,        0,0,0,        0,0};
        vecs[3]  = '{1,0,0,0,0,        0,0,  7,0, 0,0,0,0,          1,0,4,        0,0,0,        4,0};
        vecs[4]  = '{1,0,0,0,0,        0,0,  7,0, 1,32'hAA,0,0,     0,32'hAA,0,   0,0,0,        4,0};
        vecs[5]  = '{1,0,0,0,0,        7,9,  7,0, 0,0,0,0,          1,0,4,        0,0,0,        4,0};
        vecs[6]  = '{1,0,7,32'h11,4,   0,0,  7,0, 0,0,0,0,          1,0,9,        0,0,0,        9,0};
        vecs[7]  = '{1,0,0,0,0,        0,0,  7,7, 0,0,1,32'h77,     1,0,9,        0,32'h77,0,   9,9};
        vecs[8]  = '{1,0,0,0,0,        3,6,  3,0, 0,0,0,0,          0,0,0,        0,0,0,        0,0};
        vecs[9]  = '{1,0,3,32'h55,6,   0,0,  3,0, 0,0,0,0,          0,32'h55,0,   0,0,0,        6,0};
        vecs[10] = '{1,0,0,0,0,        0,0,  3,0, 0,0,0,0,          0,32'h55,0,   0,0,0,        6,0};
        vecs[11] = '{1,0,0,0,0,        8,2,  0,8, 0,0,0,0,          0,0,0,        0,0,0,        0,0};
        vecs[12] = '{1,0,8,32'h88,2,   8,10, 0,8, 0,0,0,0,          0,0,0,        0,32'h88,0,   0,2};
        vecs[13] = '{1,0,0,0,0,        0,0,  0,8, 0,0,0,0,          0,0,0,        1,0,10,       0,10};
        vecs[14] = '{1,0,0,0,0,        1,12, 0,0, 0,0,0,0,          0,0,0,        0,0,0,        0,0};
        vecs[15] = '{1,0,0,0,0,        2,13, 1,0, 0,0,0,0,          1,0,12,       0,0,0,        12,0};
        vecs[16] = '{1,1,9,32'h99,0,   4,5,  2,1, 0,0,0,0,          1,0,13,       1,0,12,       13,12};
        vecs[17] = '{1,0,0,0,0,        0,0,  4,7, 0,0,0,0,          0,0,0,        0,32'h11,0,   0,0};
        vecs[18] = '{0,0,9,32'hDEAD,0, 10,3, 9,10,0,0,0,0,          0,32'h99,0,   0,0,0,        0,0};
        vecs[19] = '{1,0,0,0,0,        0,0,  9,10,0,0,0,0,          0,32'h99,0,   0,0,0,        0,0};
        vecs[20] = '{1,0,0,32'hFFFF,7, 0,7,  0,0, 1,32'h5,1,32'h6,  0,0,0,        0,0,0,        0,0};
        vecs[21] = '{1,0,0,0,0,        0,0,  0,0, 0,0,0,0,          0,0,0,        0,0,0,        0,0};

        drive(vecs[21]);
        rst_in = 1'b1;
        model_reset();
        clock_edge();
        clock_edge();
        rst_in = 1'b0;
        #3;
        chk("reset rs1_dep", rs1_dep, 0);
        chk("reset rs1_val", rs1_val, 0);
        chk("reset rs2_tag", rs2_tag, 0);
        chk("reset rob_q1_id", rob_q1_id, 0);
        chk("reset rob_q2_id", rob_q2_id, 0);
        clock_edge();

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i]);
            #3;
            chk($sformatf("vec%0d rs1_dep", i), rs1_dep, vecs[i].d1);
            chk($sformatf("vec%0d rs1_val", i), rs1_val, vecs[i].v1);
            chk($sformatf("vec%0d rs1_tag", i), rs1_tag, vecs[i].t1);
            chk($sformatf("vec%0d rs2_dep", i), rs2_dep, vecs[i].d2);
            chk($sformatf("vec%0d rs2_val", i), rs2_val, vecs[i].v2);
            chk($sformatf("vec%0d rs2_tag", i), rs2_tag, vecs[i].t2);
            chk($sformatf("vec%0d rob_q1_id", i), rob_q1_id, vecs[i].qi1);
            chk($sformatf("vec%0d rob_q2_id", i), rob_q2_id, vecs[i].qi2);
            clock_edge();
        end

        // Random traffic over a narrow register window so renames, commits and queries collide.
        rst_in = 1'b1;
        clock_edge();
        rst_in = 1'b0;
        for (int n = 0; n < 800; n++) begin
            rst_in        = ($urandom_range(0, 99) < 2);
            rdy_in        = ($urandom_range(0, 9) != 0);
            clear_flag    = ($urandom_range(0, 19) == 0);
            commit_reg_id = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            commit_val    = $urandom;
            commit_rob_id = ($urandom_range(0, 1) == 0) ? mt[commit_reg_id] : RW'($urandom_range(0, 31));
            new_reg_id    = 5'($urandom_range(0, 7));
            new_rob_id    = RW'($urandom_range(0, 31));
            dec_rs1       = 5'($urandom_range(0, 7));
            dec_rs2       = ($urandom_range(0, 1) == 0) ? commit_reg_id : 5'($urandom_range(0, 7));
            rob_q1_ready  = ($urandom_range(0, 3) == 0);
            rob_q2_ready  = ($urandom_range(0, 3) == 0);
            rob_q1_val    = $urandom;
            rob_q2_val    = $urandom;
            #3;
            model_query(dec_rs1, rob_q1_ready, rob_q1_val, d, v, t);
            chk("rand rs1_dep", rs1_dep, d);
            chk("rand rs1_val", rs1_val, v);
            chk("rand rs1_tag", rs1_tag, t);
            model_query(dec_rs2, rob_q2_ready, rob_q2_val, d, v, t);
            chk("rand rs2_dep", rs2_dep, d);
            chk("rand rs2_val", rs2_val, v);
            chk("rand rs2_tag", rs2_tag, t);
            chk("rand rob_q1_id", rob_q1_id, mt[dec_rs1]);
            chk("rand rob_q2_id", rob_q2_id, mt[dec_rs2]);
            clock_edge();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_rename_file.md
# reg_rename_file

Architectural register file with per-register ROB rename tags. It sits between the decoder and the reorder buffer. It takes rename requests at dispatch and retires values at commit. For each source operand it answers the decoder with either a ready 32-bit value or the ROB index the operand still waits on. It uses the ROB's ready/value query port as a secondary forwarding source.

## Interface
Parameters:
- ROB_WIDTH_BIT, default 5: ROB index width (32 entries).

Ports:
- clk_in  input  1  system clock; all state updates on posedge.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global ready; when low, state holds and no update is applied.
- clear_flag  input  1  mispredict flush from ROB.
- commit_reg_id  input  5  destination of committing instruction; 0 means no write.
- commit_val  input  32  committed value.
- commit_rob_id  input  ROB_WIDTH_BIT  ROB index of committing instruction.
- new_reg_id  input  5  destination renamed at dispatch; 0 means no rename.
- new_rob_id  input  ROB_WIDTH_BIT  ROB tail index allocated to it.
- dec_rs1, dec_rs2  input  5  source register indices from the decoder.
- rob_q1_id, rob_q2_id  output  ROB_WIDTH_BIT  tag forwarded to the ROB query port.
- rob_q1_ready, rob_q2_ready  input  1  ROB reports the tagged entry has a value.
- rob_q1_val, rob_q2_val  input  32  that value.
- rs1_dep, rs2_dep  output  1  operand not yet available.
- rs1_val, rs2_val  output  32  operand value; valid when rsN_dep=0.
- rs1_tag, rs2_tag  output  ROB_WIDTH_BIT  ROB index waited on; valid when rsN_dep=1.

## Operation
- State: value[0:31] (32b), busy[0:31], tag[0:31] (ROB_WIDTH_BIT).
- Reset (rst_in=1): all value, busy and tag entries are 0. This takes priority over all other inputs.
- rdy_in=0: no state change. Combinational outputs still follow the current state.
- Commit (rdy_in=1, commit_reg_id≠0):
  - value[commit_reg_id] <= commit_val.
  - busy is cleared only if busy=1 and tag==commit_rob_id. A younger rename keeps the register busy.
- Rename (rdy_in=1, new_reg_id≠0, clear_flag=0): busy[new_reg_id] <= 1 and tag[new_reg_id] <= new_rob_id.
- Commit and rename to the same register in one cycle: the commit value is written and rename wins busy/tag (busy=1, tag=new_rob_id).
- Flush (rdy_in=1, clear_flag=1):
  - All busy bits clear and all tags go to 0.
  - Rename that cycle is ignored.
  - A commit in the same cycle still writes its value.
- x0: never written, never busy, always reads 0 with dep=0.
- Operand query for rsN (combinational), first match wins:
  1. rsN=0 → val=0, dep=0.
  2. busy[rsN]=0 → val=value[rsN], dep=0.
  3. Commit that cycle with commit_reg_id==rsN and commit_rob_id==tag[rsN] → val=commit_val, dep=0.
  4. rob_qN_ready=1 → val=rob_qN_val, dep=0.
  5. Otherwise dep=1, tag=tag[rsN], val=0.
- rob_qN_id = tag[dec_rsN] always, whether or not the register is busy.
- The query reflects state before this cycle's rename. An instruction's own rd rename never affects its own sources.
- When dep=0, rsN_tag=0.
- Query bypass (rules 3 and 4) is gated by rdy_in only through the commit inputs; the ROB already suppresses commit when not ready.

## Timing
- Query path is purely combinational, zero latency, from dec_rsN, commit inputs and rob_qN inputs.
- Commit and rename become visible in stored state from the next posedge.
- Flush: busy is cleared at the posedge where clear_flag=1 and rdy_in=1. Queries in that same cycle still see pre-flush tags.
- Output values after reset with dec_rs1=dec_rs2=0: rsN_dep=0, rsN_val=0, rsN_tag=0, rob_qN_id=0.
- No handshake or backpressure. Every valid commit and rename is accepted in the cycle it is presented.

## Test plan
- Reset, then commit x5=0x1234 (rob 3); next cycle query rs1=5 → dep=0, val=0x1234. Query rs2=0 → val=0, dep=0.
- Rename x7→rob 4; next cycle query rs1=7 with rob_q1_ready=0 → dep=1, tag=4, rob_q1_id=4. Then drive rob_q1_ready=1, val=0xAA → dep=0, val=0xAA.
- Rename x7→rob 4, then x7→rob 9. Commit x7 rob 4 val 0x11 → value=0x11, busy stays, tag=9; query → dep=1, tag=9.
- Same-cycle commit and query: x3 busy with tag 6; commit x3 rob 6 val 0x55 while dec_rs1=3 → dep=0, val=0x55 that cycle; stored value 0x55 next cycle.
- Same-cycle commit x8 (rob 2, its current tag) and rename x8→rob 10 → next cycle busy=1, tag=10, value updated.
- Flush: x1, x2 busy, clear_flag=1 with rename x4→rob 5 → next cycle no register busy, x4 not busy. rdy_in=0 during a commit → no state change.
